// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_pkg
// Description : Shared types for the instruction-fetch sequencer: the fetch
//               state encoding and the prefetch-queue entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package ifetch_pkg;

  // Width of the PC field carried in every queue entry. The top module
  // casts its ADDR_W-wide PC into and out of this field.
  localparam int unsigned C_PC_W = 32;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SLEEP = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  typedef struct packed {
    logic [15:0]       instr;
    logic [C_PC_W-1:0] pc;
    logic              fault;
  } entry_t;

endpackage
`default_nettype wire

// File: rtl/ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_queue
// Description : Synchronous prefetch FIFO of fetch entries with push, pop and
//               flush. The head entry is read straight out of storage, so no
//               consumer-side input reaches the head outputs combinationally.
// Revision    : 1.0 - initial release
// Ports       : clk, reset   - clock, synchronous active-high reset
//               push_i       - write entry_i (accepted when not full, or when
//                              a pop happens in the same cycle)
//               pop_i        - retire the head entry (ignored when empty)
//               flush_i      - discard all entries; overrides push and pop
//               entry_i      - entry to write
//               head_o       - head entry, all-zero while empty
//               full_o       - queue holds Q_DEPTH entries
//               empty_o      - queue holds no entries
// ============================================================================
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int unsigned Q_DEPTH = 2
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push_i,
  input  logic   pop_i,
  input  logic   flush_i,
  input  entry_t entry_i,
  output entry_t head_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int unsigned C_IDX_W = $clog2(Q_DEPTH);
  // One extra pointer bit tells full apart from empty when indices match.
  localparam int unsigned C_PTR_W = C_IDX_W + 1;

  logic [C_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [C_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  entry_t             mem_q [Q_DEPTH];

  logic [C_IDX_W-1:0] w_wr_idx;
  logic [C_IDX_W-1:0] w_rd_idx;
  logic               w_full;
  logic               w_empty;
  logic               w_do_pop;
  logic               w_do_push;

  assign w_wr_idx = wr_ptr_q[C_IDX_W-1:0];
  assign w_rd_idx = rd_ptr_q[C_IDX_W-1:0];
  assign w_empty  = (wr_ptr_q == rd_ptr_q);
  assign w_full   = (wr_ptr_q[C_PTR_W-1] != rd_ptr_q[C_PTR_W-1]) &&
                    (w_wr_idx == w_rd_idx);

  assign w_do_pop  = pop_i && !w_empty;
  // A pop frees the head slot on the same edge, so a full queue still
  // accepts a write when it is also being drained.
  assign w_do_push = push_i && (!w_full || w_do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (w_do_push) wr_ptr_d = wr_ptr_q + C_PTR_W'(1);
      if (w_do_pop)  rd_ptr_d = rd_ptr_q + C_PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: it is only observed through a valid pointer.
  always_ff @(posedge clk) begin
    if (w_do_push && !flush_i) begin
      mem_q[w_wr_idx] <= entry_i;
    end
  end

  assign head_o  = w_empty ? '0 : mem_q[w_rd_idx];
  assign full_o  = w_full;
  assign empty_o = w_empty;

endmodule
`default_nettype wire

// File: rtl/ifetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_ctrl
// Description : Instruction-fetch sequencer. Owns the fetch PC, reads the
//               combinational instruction ROM, buffers words in a prefetch
//               queue towards decode, handles branch redirects and
//               out-of-range fetch faults, and quiesces fetch on request
//               from the power-gating controller.
// Revision    : 1.0 - initial release
// Ports       : clk, reset      - clock, synchronous active-high reset
//               imem_addr       - ROM entry index (the fetch PC)
//               imem_instr      - ROM read data for imem_addr
//               redirect_valid  - branch/jump redirect strobe
//               redirect_pc     - redirect target entry index
//               out_valid/ready - decode handshake for the queue head
//               out_instr/pc    - head instruction and its PC
//               out_fault       - head is an out-of-range fetch
//               sleep_req/ack   - fetch quiesce request / acknowledge
// ============================================================================
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       MEM_DEPTH = 512,
  parameter int unsigned       Q_DEPTH   = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_instr,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_fault,
  input  logic              sleep_req,
  output logic              sleep_ack
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;

  entry_t w_push_entry;
  entry_t w_head;
  logic   w_full;
  logic   w_empty;
  logic   w_in_range;
  logic   w_pop;
  logic   w_push;

  assign w_in_range = (fetch_pc_q < ADDR_W'(MEM_DEPTH));
  assign w_pop      = !w_empty && out_ready;

  // Fetch only in RUN; a sleep request stops pushes in the very cycle it is
  // seen, and a redirect wins over the push because the queue is flushed.
  assign w_push = (state_q == ST_RUN) && !redirect_valid && !sleep_req &&
                  (!w_full || w_pop);

  // Out-of-range fetches never forward ROM data; the entry carries a zero
  // word and the fault flag instead.
  always_comb begin
    w_push_entry       = '0;
    w_push_entry.pc    = C_PC_W'(fetch_pc_q);
    w_push_entry.fault = !w_in_range;
    w_push_entry.instr = w_in_range ? imem_instr : 16'h0000;
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
    end else if (w_push && w_in_range) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(1);
    end

    case (state_q)
      ST_RUN: begin
        if (sleep_req) begin
          state_d = ST_DRAIN;
        end else if (w_push && !w_in_range) begin
          // PC holds at the faulting address until a redirect.
          state_d = ST_FAULT;
        end
      end
      ST_DRAIN: begin
        if (!sleep_req) begin
          state_d = ST_RUN;
        end else if (w_empty) begin
          state_d = ST_SLEEP;
        end
      end
      ST_SLEEP: begin
        if (!sleep_req) state_d = ST_RUN;
      end
      ST_FAULT: begin
        if (redirect_valid) begin
          state_d = ST_RUN;
        end else if (sleep_req) begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  ifetch_queue #(
    .Q_DEPTH (Q_DEPTH)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .flush_i (redirect_valid),
    .entry_i (w_push_entry),
    .head_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign imem_addr = fetch_pc_q;
  assign out_valid = !w_empty;
  assign out_instr = w_head.instr;
  assign out_pc    = ADDR_W'(w_head.pc);
  assign out_fault = w_head.fault;
  // Acknowledge is a decode of the state register, so it is registered and
  // drops on the same edge that leaves SLEEP.
  assign sleep_ack = (state_q == ST_SLEEP);

endmodule
`default_nettype wire
